// File: rtl/ldst_queue.sv
// ldst_queue: in-order load/store queue between the core memory stage and the
// cache. Each request is tagged with its slot index, issued in program order,
// matched with returning load data by id and retired in program order.
module ldst_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_BITS    = 3,
  parameter int REG_BITS   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic                  req_rw_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [REG_BITS-1:0]   req_dst_i,
  output logic                  req_ready_o,
  output logic                  wb_valid_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic [REG_BITS-1:0]   wb_dst_o,
  output logic                  mem_valid_o,
  output logic                  mem_rw_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [ID_BITS-1:0]    mem_id_o,
  input  logic                  mem_stall_i,
  input  logic                  mem_ready_i,
  input  logic [ID_BITS-1:0]    mem_id_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  localparam int DEPTH = 1 << ID_BITS;
  localparam logic [ID_BITS:0] PTR_ONE  = {{ID_BITS{1'b0}}, 1'b1};
  localparam logic [ID_BITS:0] DEPTH_P  = {1'b1, {ID_BITS{1'b0}}};

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_ISSUED = 2'd2,
    ST_DONE   = 2'd3
  } entry_state_e;

  entry_state_e          state_r [DEPTH];
  logic                  rw_r    [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_r  [DEPTH];
  logic [DATA_WIDTH-1:0] data_r  [DEPTH];
  logic [REG_BITS-1:0]   dst_r   [DEPTH];

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  logic [ID_BITS:0]   alloc_ptr_r, issue_ptr_r, retire_ptr_r, count_r;
  logic [ID_BITS-1:0] alloc_idx_s, issue_idx_s, retire_idx_s;
  logic               alloc_s, issue_s, resp_s, retire_s;
  logic [ID_BITS:0]   count_next_s;

  // Decide which of alloc/issue/response/retire fire at the coming edge.
  always_comb begin
    alloc_idx_s  = alloc_ptr_r[ID_BITS-1:0];
    issue_idx_s  = issue_ptr_r[ID_BITS-1:0];
    retire_idx_s = retire_ptr_r[ID_BITS-1:0];
    alloc_s      = 1'b0;
    issue_s      = 1'b0;
    resp_s       = 1'b0;
    retire_s     = 1'b0;
    count_next_s = count_r;

    alloc_s = req_valid_i & req_ready_o;

    if ((issue_ptr_r != alloc_ptr_r) && (state_r[issue_idx_s] == ST_PEND) && !mem_stall_i) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end

    // Only an outstanding load accepts data; anything else (e.g. stale after reset) is dropped.
    if (mem_ready_i && (state_r[mem_id_i] == ST_ISSUED) && !rw_r[mem_id_i]) begin
      resp_s = 1'b1;
    end else begin
      resp_s = 1'b0;
    end

    if (state_r[retire_idx_s] == ST_DONE) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end

    case ({alloc_s, retire_s})
      2'b10:   count_next_s = count_r + PTR_ONE;
      2'b01:   count_next_s = count_r - PTR_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Entry storage and per-entry lifecycle; each event targets a distinct entry state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_r[i] <= ST_FREE;
        rw_r[i]    <= 1'b0;
        addr_r[i]  <= '0;
        data_r[i]  <= '0;
        dst_r[i]   <= '0;
      end
    end else begin
      if (retire_s) begin
        state_r[retire_idx_s] <= ST_FREE;
      end
      if (resp_s) begin
        state_r[mem_id_i] <= ST_DONE;
        data_r[mem_id_i]  <= mem_data_i;
      end
      if (issue_s) begin
        state_r[issue_idx_s] <= rw_r[issue_idx_s] ? ST_DONE : ST_ISSUED;
      end
      if (alloc_s) begin
        state_r[alloc_idx_s] <= ST_PEND;
        rw_r[alloc_idx_s]    <= req_rw_i;
        addr_r[alloc_idx_s]  <= req_addr_i;
        data_r[alloc_idx_s]  <= req_data_i;
        dst_r[alloc_idx_s]   <= req_dst_i;
      end
    end
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_ptr_r  <= '0;
      issue_ptr_r  <= '0;
      retire_ptr_r <= '0;
      count_r      <= '0;
      req_ready_o  <= 1'b1;
    end else begin
      if (alloc_s)  alloc_ptr_r  <= alloc_ptr_r + PTR_ONE;
      if (issue_s)  issue_ptr_r  <= issue_ptr_r + PTR_ONE;
      if (retire_s) retire_ptr_r <= retire_ptr_r + PTR_ONE;
      count_r     <= count_next_s;
      req_ready_o <= (count_next_s < DEPTH_P);
    end
  end

  // Cache request port: one-cycle valid pulse, payload held between issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid_o <= 1'b0;
      mem_rw_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_id_o    <= '0;
    end else begin
      mem_valid_o <= issue_s;
      if (issue_s) begin
        mem_rw_o   <= rw_r[issue_idx_s];
        mem_addr_o <= addr_r[issue_idx_s];
        mem_data_o <= data_r[issue_idx_s];
        mem_id_o   <= issue_idx_s;
      end
    end
  end

  // Register-file writeback: pulse for each retired load, payload held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_o <= 1'b0;
      wb_data_o  <= '0;
      wb_dst_o   <= '0;
    end else begin
      wb_valid_o <= retire_s & ~rw_r[retire_idx_s];
      if (retire_s && !rw_r[retire_idx_s]) begin
        wb_data_o <= data_r[retire_idx_s];
        wb_dst_o  <= dst_r[retire_idx_s];
      end
    end
  end

endmodule

// File: tb/tb_ldst_queue.sv
// tb_ldst_queue: directed scenarios plus randomized traffic, checked every
// cycle against a program-order queue model of the load/store queue.
module tb_ldst_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_rw_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0;
  logic [31:0] req_data_i = 32'd0;
  logic [4:0]  req_dst_i = 5'd0;
  logic        req_ready_o;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_dst_o;
  logic        mem_valid_o;
  logic        mem_rw_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [2:0]  mem_id_o;
  logic        mem_stall_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic [2:0]  mem_id_i = 3'd0;
  logic [31:0] mem_data_i = 32'd0;

  ldst_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_BITS(3), .REG_BITS(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_rw_i(req_rw_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_dst_i(req_dst_i), .req_ready_o(req_ready_o),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_dst_o(wb_dst_o),
    .mem_valid_o(mem_valid_o), .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_id_o(mem_id_o), .mem_stall_i(mem_stall_i),
    .mem_ready_i(mem_ready_i), .mem_id_i(mem_id_i), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: entries in program order, slot id = allocation count mod DEPTH.
  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  dst;
    logic [2:0]  id;
    logic        issued;
    logic        done;
  } ent_t;

  ent_t        q[$];
  int          n_issued;
  int unsigned seq;
  logic        e_ready, e_mem_valid, e_mem_rw, e_wb_valid;
  logic [31:0] e_mem_addr, e_mem_data, e_wb_data;
  logic [2:0]  e_mem_id;
  logic [4:0]  e_wb_dst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    n_issued = 0; seq = 0;
    e_ready = 1'b1; e_mem_valid = 1'b0; e_mem_rw = 1'b0; e_wb_valid = 1'b0;
    e_mem_addr = 32'd0; e_mem_data = 32'd0; e_wb_data = 32'd0;
    e_mem_id = 3'd0; e_wb_dst = 5'd0;
  endtask

  task automatic model_step();
    bit   do_ret, do_iss;
    int   resp_idx;
    ent_t e;
    do_ret   = (q.size() > 0) && q[0].done;
    do_iss   = (n_issued < q.size()) && !mem_stall_i;
    resp_idx = -1;
    if (mem_ready_i)
      foreach (q[i]) if (q[i].id == mem_id_i && q[i].issued && !q[i].rw && !q[i].done) resp_idx = i;
    e_mem_valid = do_iss;
    if (do_iss) begin
      e_mem_rw = q[n_issued].rw; e_mem_addr = q[n_issued].addr;
      e_mem_data = q[n_issued].data; e_mem_id = q[n_issued].id;
    end
    e_wb_valid = do_ret && !q[0].rw;
    if (e_wb_valid) begin
      e_wb_data = q[0].data; e_wb_dst = q[0].dst;
    end
    if (resp_idx >= 0) begin
      e = q[resp_idx]; e.done = 1'b1; e.data = mem_data_i; q[resp_idx] = e;
    end
    if (do_iss) begin
      e = q[n_issued]; e.issued = 1'b1; if (e.rw) e.done = 1'b1; q[n_issued] = e;
      n_issued++;
    end
    if (do_ret) begin
      void'(q.pop_front());
      n_issued--;
    end
    if (req_valid_i && e_ready) begin
      e = '{rw: req_rw_i, addr: req_addr_i, data: req_data_i, dst: req_dst_i,
            id: 3'(seq), issued: 1'b0, done: 1'b0};
      q.push_back(e);
      seq++;
    end
    e_ready = (q.size() < DEPTH);
  endtask

  task automatic check_outputs();
    check("ready",     64'(req_ready_o), 64'(e_ready));
    check("mem_valid", 64'(mem_valid_o), 64'(e_mem_valid));
    check("mem_rw",    64'(mem_rw_o),    64'(e_mem_rw));
    check("mem_addr",  64'(mem_addr_o),  64'(e_mem_addr));
    check("mem_data",  64'(mem_data_o),  64'(e_mem_data));
    check("mem_id",    64'(mem_id_o),    64'(e_mem_id));
    check("wb_valid",  64'(wb_valid_o),  64'(e_wb_valid));
    check("wb_data",   64'(wb_data_o),   64'(e_wb_data));
    check("wb_dst",    64'(wb_dst_o),    64'(e_wb_dst));
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_in();
    req_valid_i = 1'b0; mem_ready_i = 1'b0; mem_stall_i = 1'b0;
  endtask

  task automatic set_req(input logic rw, input logic [31:0] addr, input logic [31:0] data, input logic [4:0] dst);
    req_valid_i = 1'b1; req_rw_i = rw; req_addr_i = addr; req_data_i = data; req_dst_i = dst;
  endtask

  task automatic respond(input logic [2:0] id, input logic [31:0] data);
    mem_ready_i = 1'b1; mem_id_i = id; mem_data_i = data;
  endtask

  // Called at a falling edge: reset drops asynchronously, held for two edges.
  task automatic do_reset();
    idle_in();
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Single load, single response.
    do_reset();
    set_req(1'b0, 32'h100, 32'd0, 5'd3); cycle();
    req_valid_i = 1'b0; cycle();
    check("t1_mem_valid", 64'(mem_valid_o), 64'd1);
    check("t1_mem_id",    64'(mem_id_o),    64'd0);
    respond(3'd0, 32'hDEADBEEF); cycle();
    mem_ready_i = 1'b0; cycle();
    check("t1_wb_valid", 64'(wb_valid_o), 64'd1);
    check("t1_wb_dst",   64'(wb_dst_o),   64'd3);
    check("t1_wb_data",  64'(wb_data_o),  64'hDEADBEEF);
    cycle();

    // Out-of-order responses, in-order writeback.
    do_reset();
    set_req(1'b0, 32'h40, 32'd0, 5'd4); cycle();
    set_req(1'b0, 32'h44, 32'd0, 5'd5); cycle();
    req_valid_i = 1'b0; repeat (2) cycle();
    respond(3'd1, 32'h1111_0001); cycle();
    mem_ready_i = 1'b0; repeat (2) cycle();
    check("t2_no_early_wb", 64'(wb_valid_o), 64'd0);
    respond(3'd0, 32'h1111_0000); cycle();
    mem_ready_i = 1'b0; cycle();
    check("t2_wb0_valid", 64'(wb_valid_o), 64'd1);
    check("t2_wb0_dst",   64'(wb_dst_o),   64'd4);
    cycle();
    check("t2_wb1_valid", 64'(wb_valid_o), 64'd1);
    check("t2_wb1_dst",   64'(wb_dst_o),   64'd5);
    check("t2_wb1_data",  64'(wb_data_o),  64'h1111_0001);

    // Fill to 8, hold the 9th, free one slot, wrap to slot 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_req(1'b0, 32'h1000 + 32'(i * 4), 32'd0, 5'(i)); cycle();
    end
    check("t3_full_ready", 64'(req_ready_o), 64'd0);
    set_req(1'b0, 32'h2000, 32'd0, 5'd9);
    repeat (3) cycle();
    check("t3_held_ready", 64'(req_ready_o), 64'd0);
    respond(3'd0, 32'h0000_1234); cycle();
    mem_ready_i = 1'b0; cycle();
    check("t3_ready_back", 64'(req_ready_o), 64'd1);
    cycle();
    req_valid_i = 1'b0; cycle();
    check("t3_wrap_valid", 64'(mem_valid_o), 64'd1);
    check("t3_wrap_id",    64'(mem_id_o),    64'd0);
    check("t3_wrap_addr",  64'(mem_addr_o),  64'h2000);

    // Five stalled cycles, then three back-to-back issues.
    do_reset();
    mem_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b0, 32'h300 + 32'(i), 32'd0, 5'(i + 1)); cycle();
    end
    req_valid_i = 1'b0; repeat (2) cycle();
    check("t4_stall_quiet", 64'(mem_valid_o), 64'd0);
    mem_stall_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_burst_valid", 64'(mem_valid_o), 64'd1);
      check("t4_burst_id",    64'(mem_id_o),    64'(i));
    end

    // Store then load to the same address.
    do_reset();
    set_req(1'b1, 32'h200, 32'h55, 5'd0); cycle();
    set_req(1'b0, 32'h200, 32'd0, 5'd7); cycle();
    check("t5_st_rw",   64'(mem_rw_o),   64'd1);
    check("t5_st_data", 64'(mem_data_o), 64'h55);
    req_valid_i = 1'b0; cycle();
    check("t5_st_no_wb", 64'(wb_valid_o), 64'd0);
    check("t5_ld_id",    64'(mem_id_o),   64'd1);
    respond(3'd1, 32'h55); cycle();
    mem_ready_i = 1'b0; cycle();
    check("t5_ld_wb",   64'(wb_valid_o), 64'd1);
    check("t5_ld_data", 64'(wb_data_o),  64'h55);
    check("t5_ld_dst",  64'(wb_dst_o),   64'd7);

    // Reset with two loads in flight; late responses must be dropped.
    set_req(1'b0, 32'h500, 32'd0, 5'd10); cycle();
    set_req(1'b0, 32'h504, 32'd0, 5'd11); cycle();
    req_valid_i = 1'b0; repeat (2) cycle();
    do_reset();
    respond(3'd0, 32'hAAAA_0000); cycle();
    respond(3'd1, 32'hAAAA_0001); cycle();
    mem_ready_i = 1'b0;
    repeat (2) begin
      cycle();
      check("t6_no_wb", 64'(wb_valid_o), 64'd0);
    end
    check("t6_ready", 64'(req_ready_o), 64'd1);

    // Randomized traffic with a reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      if (!(req_valid_i && !e_ready)) begin
        req_valid_i = ($urandom_range(0, 99) < 60);
        req_rw_i    = ($urandom_range(0, 99) < 30);
        req_addr_i  = $urandom;
        req_data_i  = $urandom;
        req_dst_i   = 5'($urandom);
      end
      mem_stall_i = ($urandom_range(0, 99) < 20);
      mem_ready_i = 1'b0;
      mem_data_i  = $urandom;
      begin
        int cand[$];
        foreach (q[i]) if (q[i].issued && !q[i].rw && !q[i].done) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(0, 99) < 50) begin
          mem_ready_i = 1'b1;
          mem_id_i    = q[cand[$urandom_range(0, cand.size() - 1)]].id;
        end else if ($urandom_range(0, 99) < 5) begin
          mem_ready_i = 1'b1;
          mem_id_i    = 3'($urandom);
        end
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
